// File: rtl/pwm_pulse_decoder.sv
// RC-style PWM receiver: measures pulse high time in microseconds and maps it to a
// 5-bit speed code, with glitch/over-length rejection and loss-of-signal fallback.
module pwm_pulse_decoder #(
  parameter int unsigned TICK_DIV     = 50,
  parameter int unsigned MIN_US       = 1000,
  parameter int unsigned MAX_US       = 2000,
  parameter int unsigned GLITCH_US    = 800,
  parameter int unsigned OVER_US      = 2200,
  parameter int unsigned TIMEOUT_US   = 25000,
  parameter int unsigned NEUTRAL_CODE = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [4:0]  speed_code,
  output logic        code_valid,
  output logic [15:0] pulse_width_us,
  output logic        signal_lost,
  output logic        pulse_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_US + 1);

  typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH} state_t;

  state_t          state, state_nxt;
  logic            s1, s2, prev;
  logic            rise, fall, tick;
  logic [PW-1:0]   presc;
  logic [15:0]     width, w_now, diff, step;
  logic [TW-1:0]   los_cnt;
  logic            timeout, accept, err;
  logic [4:0]      code;

  // Synchroniser resets high so a pulse already in progress at reset release is
  // treated as "not yet low" and never produces a spurious rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;
  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               presc <= '0;
    else if (rise || tick) presc <= '0;
    else                   presc <= presc + 1'b1;
  end

  // Width including this cycle's tick, so a pulse of N*TICK_DIV cycles reads N us.
  assign w_now = (tick && width != 16'hFFFF) ? width + 16'd1 : width;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                width <= '0;
    else if (rise)          width <= '0;
    else if (state == HIGH) width <= w_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   los_cnt <= '0;
    else if (rise)                             los_cnt <= '0;
    else if (tick && los_cnt != TW'(TIMEOUT_US)) los_cnt <= los_cnt + 1'b1;
  end

  assign timeout = (los_cnt == TW'(TIMEOUT_US));

  always_comb begin
    diff = w_now - 16'(MIN_US);
    step = diff >> 5;
    if (w_now < 16'(MIN_US)) code = 5'd0;
    else if (step > 16'd31)  code = 5'd31;
    else                     code = step[4:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_LOW;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err       = 1'b0;
    case (state)
      WAIT_LOW: if (!s2) state_nxt = ARMED;
      ARMED:    if (rise) state_nxt = HIGH;
      HIGH: begin
        if (w_now > 16'(OVER_US)) begin
          err       = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (fall) begin
          state_nxt = ARMED;
          if (w_now < 16'(GLITCH_US)) err = 1'b1;
          else                        accept = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  // An accepted pulse takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_code     <= 5'(NEUTRAL_CODE);
      code_valid     <= 1'b0;
      pulse_width_us <= '0;
      signal_lost    <= 1'b1;
      pulse_err      <= 1'b0;
    end else begin
      code_valid <= accept;
      pulse_err  <= err;
      if (accept) begin
        speed_code     <= code;
        pulse_width_us <= w_now;
        signal_lost    <= 1'b0;
      end else if (timeout) begin
        speed_code  <= 5'(NEUTRAL_CODE);
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// Directed bench for pwm_pulse_decoder: 2 clocks per us, shortened loss-of-signal timeout.
module tb_pwm_pulse_decoder;
  localparam int TD = 2;
  localparam int TO = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm;
  logic [4:0]  speed_code;
  logic        code_valid;
  logic [15:0] pulse_width_us;
  logic        signal_lost;
  logic        pulse_err;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int err_cnt = 0;
  int cv_snap, err_snap;

  pwm_pulse_decoder #(.TICK_DIV(TD), .TIMEOUT_US(TO)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm), .speed_code(speed_code),
    .code_valid(code_valid), .pulse_width_us(pulse_width_us),
    .signal_lost(signal_lost), .pulse_err(pulse_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (pulse_err)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int w, input int gap);
    pwm = 1'b1;
    repeat (w * TD) @(negedge clk);
    pwm = 1'b0;
    repeat (gap * TD) @(negedge clk);
  endtask

  int tw[3] = '{1000, 1992, 2150};
  int tc[3] = '{0, 31, 31};

  initial begin
    rst = 1'b1;
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code", speed_code, 15);
    chk("rst_cv", code_valid, 0);
    chk("rst_width", pulse_width_us, 0);
    chk("rst_lost", signal_lost, 1);
    chk("rst_err", pulse_err, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_no_strobe", cv_cnt + err_cnt, 0);

    // 1) 1500 us frames, first one with exact strobe latency
    pwm = 1'b1;
    repeat (1500 * TD) @(negedge clk);
    pwm = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat_cv_early", code_valid, 0);
    @(negedge clk);
    chk("lat_cv_on", code_valid, 1);
    chk("f1_code", speed_code, 15);
    chk("f1_width", pulse_width_us, 1500);
    chk("f1_lost", signal_lost, 0);
    @(negedge clk);
    chk("lat_cv_off", code_valid, 0);
    repeat (1000 * TD) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      cv_snap = cv_cnt;
      pulse(1500, 1000);
      chk("frame_cv", cv_cnt, cv_snap + 1);
      chk("frame_width", pulse_width_us, 1500);
    end

    // 2) boundary widths
    for (int i = 0; i < 3; i++) begin
      cv_snap = cv_cnt;
      pulse(tw[i], 300);
      chk("bnd_cv", cv_cnt, cv_snap + 1);
      chk("bnd_code", speed_code, tc[i]);
      chk("bnd_width", pulse_width_us, tw[i]);
    end

    // 3) sub-minimum accepted, glitch rejected
    pulse(900, 300);
    chk("w900_code", speed_code, 0);
    chk("w900_width", pulse_width_us, 900);
    cv_snap = cv_cnt; err_snap = err_cnt;
    pulse(500, 300);
    chk("glitch_err", err_cnt, err_snap + 1);
    chk("glitch_no_cv", cv_cnt, cv_snap);
    chk("glitch_code", speed_code, 0);
    chk("glitch_width", pulse_width_us, 900);

    // 4) stuck high: error lands exactly when width reaches 2201 us
    cv_snap = cv_cnt; err_snap = err_cnt;
    pwm = 1'b1;
    repeat (2 + 2201 * TD) @(negedge clk);
    chk("stuck_err_early", pulse_err, 0);
    @(negedge clk);
    chk("stuck_err_on", pulse_err, 1);
    repeat (3000 * TD - (3 + 2201 * TD)) @(negedge clk);
    pwm = 1'b0;
    repeat (300 * TD) @(negedge clk);
    chk("stuck_err_cnt", err_cnt, err_snap + 1);
    chk("stuck_no_cv", cv_cnt, cv_snap);
    chk("stuck_code", speed_code, 0);
    pulse(1500, 300);
    chk("recover_cv", cv_cnt, cv_snap + 1);
    chk("recover_code", speed_code, 15);

    // 5) loss of signal after an 1800 us pulse
    pulse(1800, 50);
    chk("pre_los_code", speed_code, 25);
    cv_snap = cv_cnt;
    repeat (2100 * TD) @(negedge clk);
    chk("los_not_yet", signal_lost, 0);
    repeat (150 * TD) @(negedge clk);
    chk("los_set", signal_lost, 1);
    chk("los_code", speed_code, 15);
    chk("los_no_cv", cv_cnt, cv_snap);
    pulse(1800, 300);
    chk("los_clear", signal_lost, 0);
    chk("los_recode", speed_code, 25);

    // 6) reset in the middle of a pulse
    pwm = 1'b1;
    repeat (600 * TD) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_code", speed_code, 15);
    chk("mid_rst_width", pulse_width_us, 0);
    chk("mid_rst_lost", signal_lost, 1);
    rst = 1'b0;
    cv_snap = cv_cnt; err_snap = err_cnt;
    repeat (400 * TD) @(negedge clk);
    pwm = 1'b0;
    repeat (300 * TD) @(negedge clk);
    chk("partial_no_cv", cv_cnt, cv_snap);
    chk("partial_no_err", err_cnt, err_snap);
    pulse(1200, 300);
    chk("post_rst_code", speed_code, 6);
    chk("post_rst_width", pulse_width_us, 1200);
    chk("post_rst_lost", signal_lost, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
